// File: rtl/acc_writeback.sv
// -----------------------------------------------------------------------------
// acc_writeback
//   Execution / write-back stage of the MCU datapath. Accepts one decoded
//   operation per three cycles over a valid/ready handshake, drives the
//   external combinational ALU with registered operands and function code,
//   samples the ALU result/flags two edges after accept and updates the
//   accumulator and the conditional-execution flags.
//
// Build option:
//   ACC_SAT_EN - when defined, results written to acc are clamped to
//                [SAT_MIN, SAT_MAX] and `sat` reports clamping. When undefined,
//                acc wraps in WIDTH-bit two's complement and `sat` is 0.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   op_valid/op_ready       operation handshake (op_ready high only in IDLE)
//   op_kind, op_funct       00 MOV, 01 ARITH, 10 TEST, 11 CLRC; ALU function code
//   op_src                  signed operand
//   alu_in0/alu_in1/alu_funct  registered ALU drive (alu_in0 is the accumulator)
//   alu_out, alu_overflow, alu_gr, alu_le, alu_eq  ALU result and status
//   acc                     accumulator
//   cond_plus/cond_minus    conditional-execution enables
//   wb_valid, sat, op_err   retire pulse, clamp indication, illegal-funct pulse
// -----------------------------------------------------------------------------
module acc_writeback #(
    parameter int WIDTH   = 11,
    parameter int SAT_MAX = 999,
    parameter int SAT_MIN = -999
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [1:0]       op_kind,
    input  logic [3:0]       op_funct,
    input  logic [WIDTH-1:0] op_src,
    output logic [WIDTH-1:0] alu_in0,
    output logic [WIDTH-1:0] alu_in1,
    output logic [3:0]       alu_funct,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_overflow,
    input  logic             alu_gr,
    input  logic             alu_le,
    input  logic             alu_eq,
    output logic [WIDTH-1:0] acc,
    output logic             cond_plus,
    output logic             cond_minus,
    output logic             wb_valid,
    output logic             sat,
    output logic             op_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETTLE = 2'b01,
        WRITE  = 2'b10
    } state_t;

    localparam logic [1:0] KIND_MOV   = 2'b00;
    localparam logic [1:0] KIND_ARITH = 2'b01;
    localparam logic [1:0] KIND_TEST  = 2'b10;
    localparam logic [1:0] KIND_CLRC  = 2'b11;

    localparam logic [3:0] F_PARK = 4'b0000;
    localparam logic [3:0] F_ADD  = 4'b1000;
    localparam logic [3:0] F_SUB  = 4'b1001;
    localparam logic [3:0] F_MUL  = 4'b1010;
    localparam logic [3:0] F_NOT  = 4'b1011;
    localparam logic [3:0] F_TEQ  = 4'b1100;
    localparam logic [3:0] F_TGT  = 4'b1101;
    localparam logic [3:0] F_TLT  = 4'b1110;

    state_t           state_r, state_s;
    logic [1:0]       kind_r, kind_s;
    logic [3:0]       funct_r, funct_s;
    logic [WIDTH-1:0] alu_in0_r, alu_in0_s;
    logic [WIDTH-1:0] alu_in1_r, alu_in1_s;
    logic [3:0]       alu_funct_r, alu_funct_s;
    logic [WIDTH-1:0] acc_r, acc_s;
    logic             cond_plus_r, cond_plus_s;
    logic             cond_minus_r, cond_minus_s;
    logic             wb_valid_r, wb_valid_s;
    logic             sat_r, sat_s;
    logic             op_err_r, op_err_s;

    logic [WIDTH-1:0] raw_s;        // unclamped value to be written to acc
    logic [WIDTH-1:0] clamp_val_s;  // value after the (optional) clamp
    logic             clamp_sat_s;  // clamp changed the value

`ifdef ACC_SAT_EN
    localparam logic signed [WIDTH-1:0] SAT_MAX_W = WIDTH'(SAT_MAX);
    localparam logic signed [WIDTH-1:0] SAT_MIN_W = WIDTH'(SAT_MIN);

    logic ovf_s;
    logic neg_s;

    // Returns {changed, clamped}. On overflow the wrapped value is meaningless,
    // so the bound is picked from the sign of the true result instead.
    function automatic logic [WIDTH:0] sat_clamp(
        input logic signed [WIDTH-1:0] value,
        input logic                    ovf,
        input logic                    neg
    );
        logic signed [WIDTH-1:0] res;
        if (ovf) begin
            res = neg ? SAT_MIN_W : SAT_MAX_W;
        end else if (value > SAT_MAX_W) begin
            res = SAT_MAX_W;
        end else if (value < SAT_MIN_W) begin
            res = SAT_MIN_W;
        end else begin
            res = value;
        end
        return {(res != value), res};
    endfunction

    // Overflow and true-result sign for the clamp; MOV never overflows.
    always_comb begin
        ovf_s = 1'b0;
        neg_s = alu_in0_r[WIDTH-1];
        if (kind_r == KIND_ARITH) begin
            ovf_s = alu_overflow;
            if (funct_r == F_MUL) begin
                neg_s = alu_in0_r[WIDTH-1] ^ alu_in1_r[WIDTH-1];
            end else begin
                neg_s = alu_in0_r[WIDTH-1];
            end
        end else begin
            ovf_s = 1'b0;
        end
    end

    // Saturating clamp of the write-back value.
    always_comb begin
        {clamp_sat_s, clamp_val_s} = sat_clamp(raw_s, ovf_s, neg_s);
    end
`else
    logic unused_ovf;

    assign clamp_val_s = raw_s;
    assign clamp_sat_s = 1'b0;
    assign unused_ovf  = alu_overflow;
`endif

    // Write-back source: MOV writes the captured operand, ARITH the ALU result.
    always_comb begin
        if (kind_r == KIND_MOV) begin
            raw_s = alu_in1_r;
        end else begin
            raw_s = alu_out;
        end
    end

    // Next-state and next-register decode for the IDLE/SETTLE/WRITE sequence.
    always_comb begin
        state_s      = state_r;
        kind_s       = kind_r;
        funct_s      = funct_r;
        alu_in0_s    = alu_in0_r;
        alu_in1_s    = alu_in1_r;
        alu_funct_s  = alu_funct_r;
        acc_s        = acc_r;
        cond_plus_s  = cond_plus_r;
        cond_minus_s = cond_minus_r;
        wb_valid_s   = 1'b0;
        sat_s        = 1'b0;
        op_err_s     = 1'b0;
        case (state_r)
            IDLE: begin
                alu_funct_s = F_PARK;
                if (op_valid) begin
                    kind_s    = op_kind;
                    funct_s   = op_funct;
                    alu_in0_s = acc_r;
                    alu_in1_s = op_src;
                    // MOV/CLRC keep the park code so the ALU stays quiet.
                    if ((op_kind == KIND_ARITH) || (op_kind == KIND_TEST)) begin
                        alu_funct_s = op_funct;
                    end else begin
                        alu_funct_s = F_PARK;
                    end
                    state_s = SETTLE;
                end else begin
                    state_s = IDLE;
                end
            end
            SETTLE: begin
                state_s = WRITE;
            end
            WRITE: begin
                wb_valid_s  = 1'b1;
                alu_funct_s = F_PARK;
                state_s     = IDLE;
                case (kind_r)
                    KIND_MOV: begin
                        acc_s = clamp_val_s;
                        sat_s = clamp_sat_s;
                    end
                    KIND_ARITH: begin
                        if ((funct_r == F_ADD) || (funct_r == F_SUB) ||
                            (funct_r == F_MUL) || (funct_r == F_NOT)) begin
                            acc_s = clamp_val_s;
                            sat_s = clamp_sat_s;
                        end else begin
                            op_err_s = 1'b1;
                        end
                    end
                    KIND_TEST: begin
                        case (funct_r)
                            F_TGT: begin
                                cond_plus_s  = alu_gr;
                                cond_minus_s = ~alu_gr;
                            end
                            F_TLT: begin
                                cond_plus_s  = alu_le;
                                cond_minus_s = ~alu_le;
                            end
                            F_TEQ: begin
                                cond_plus_s  = alu_eq;
                                cond_minus_s = ~alu_eq;
                            end
                            default: begin
                                op_err_s = 1'b1;
                            end
                        endcase
                    end
                    KIND_CLRC: begin
                        cond_plus_s  = 1'b0;
                        cond_minus_s = 1'b0;
                    end
                    default: begin
                        op_err_s = 1'b1;
                    end
                endcase
            end
            default: begin
                state_s     = IDLE;
                alu_funct_s = F_PARK;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            kind_r       <= 2'b00;
            funct_r      <= 4'b0000;
            alu_in0_r    <= {WIDTH{1'b0}};
            alu_in1_r    <= {WIDTH{1'b0}};
            alu_funct_r  <= 4'b0000;
            acc_r        <= {WIDTH{1'b0}};
            cond_plus_r  <= 1'b0;
            cond_minus_r <= 1'b0;
            wb_valid_r   <= 1'b0;
            sat_r        <= 1'b0;
            op_err_r     <= 1'b0;
        end else begin
            state_r      <= state_s;
            kind_r       <= kind_s;
            funct_r      <= funct_s;
            alu_in0_r    <= alu_in0_s;
            alu_in1_r    <= alu_in1_s;
            alu_funct_r  <= alu_funct_s;
            acc_r        <= acc_s;
            cond_plus_r  <= cond_plus_s;
            cond_minus_r <= cond_minus_s;
            wb_valid_r   <= wb_valid_s;
            sat_r        <= sat_s;
            op_err_r     <= op_err_s;
        end
    end

    assign op_ready   = (state_r == IDLE);
    assign alu_in0    = alu_in0_r;
    assign alu_in1    = alu_in1_r;
    assign alu_funct  = alu_funct_r;
    assign acc        = acc_r;
    assign cond_plus  = cond_plus_r;
    assign cond_minus = cond_minus_r;
    assign wb_valid   = wb_valid_r;
    assign sat        = sat_r;
    assign op_err     = op_err_r;

endmodule

// File: tb/tb_acc_writeback.sv
// -----------------------------------------------------------------------------
// tb_acc_writeback
//   Directed, table-driven bench for acc_writeback. A small behavioural ALU
//   closes the loop; each table row is one operation with hand-computed
//   results for both the clamping and the wrapping build.
// -----------------------------------------------------------------------------
module tb_acc_writeback;

    localparam int W = 11;
`ifdef ACC_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic         clk;
    logic         reset;
    logic         op_valid;
    logic         op_ready;
    logic [1:0]   op_kind;
    logic [3:0]   op_funct;
    logic [W-1:0] op_src;
    logic [W-1:0] alu_in0;
    logic [W-1:0] alu_in1;
    logic [3:0]   alu_funct;
    logic [W-1:0] alu_out;
    logic         alu_overflow;
    logic         alu_gr;
    logic         alu_le;
    logic         alu_eq;
    logic [W-1:0] acc;
    logic         cond_plus;
    logic         cond_minus;
    logic         wb_valid;
    logic         sat;
    logic         op_err;

    int checks;
    int errors;

    acc_writeback #(.WIDTH(W), .SAT_MAX(999), .SAT_MIN(-999)) dut (
        .clk         (clk),
        .reset       (reset),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_kind     (op_kind),
        .op_funct    (op_funct),
        .op_src      (op_src),
        .alu_in0     (alu_in0),
        .alu_in1     (alu_in1),
        .alu_funct   (alu_funct),
        .alu_out     (alu_out),
        .alu_overflow(alu_overflow),
        .alu_gr      (alu_gr),
        .alu_le      (alu_le),
        .alu_eq      (alu_eq),
        .acc         (acc),
        .cond_plus   (cond_plus),
        .cond_minus  (cond_minus),
        .wb_valid    (wb_valid),
        .sat         (sat),
        .op_err      (op_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: full-precision result, wrapped output, overflow flag.
    int a_i, b_i, r_i;
    always_comb begin
        a_i = $signed(alu_in0);
        b_i = $signed(alu_in1);
        case (alu_funct)
            4'b1000: r_i = a_i + b_i;
            4'b1001: r_i = a_i - b_i;
            4'b1010: r_i = a_i * b_i;
            4'b1011: r_i = ~a_i;
            default: r_i = 0;
        endcase
        alu_out      = r_i[W-1:0];
        alu_overflow = (r_i > 1023) || (r_i < -1024);
        alu_gr       = (a_i > b_i);
        alu_le       = (a_i < b_i);
        alu_eq       = (a_i == b_i);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0] kind;
        logic [3:0] funct;
        int         src;
        int         acc_sat;
        int         acc_wrap;
        bit         sat;
        bit         err;
        bit         cp;
        bit         cm;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    // Issue one op from IDLE and check the whole retire sequence.
    task automatic run_vec(input vec_t v, input int idx);
        int prev_acc;
        int lat;
        int exp_f;
        @(negedge clk);
        chk($sformatf("v%0d ready_idle", idx), int'(op_ready), 1);
        prev_acc = $signed(acc);
        op_valid = 1'b1;
        op_kind  = v.kind;
        op_funct = v.funct;
        op_src   = W'(v.src);
        @(posedge clk);
        #1 op_valid = 1'b0;
        @(negedge clk);
        exp_f = ((v.kind == 2'b01) || (v.kind == 2'b10)) ? int'(v.funct) : 0;
        chk($sformatf("v%0d ready_busy", idx), int'(op_ready), 0);
        chk($sformatf("v%0d alu_funct", idx), int'(alu_funct), exp_f);
        chk($sformatf("v%0d alu_in0", idx), $signed(alu_in0), prev_acc);
        chk($sformatf("v%0d alu_in1", idx), $signed(alu_in1), v.src);
        lat = 0;
        while (!wb_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("v%0d wb_latency", idx), lat, 2);
        chk($sformatf("v%0d acc", idx), $signed(acc), SAT_EN ? v.acc_sat : v.acc_wrap);
        chk($sformatf("v%0d sat", idx), int'(sat), SAT_EN ? int'(v.sat) : 0);
        chk($sformatf("v%0d op_err", idx), int'(op_err), int'(v.err));
        chk($sformatf("v%0d cond_plus", idx), int'(cond_plus), int'(v.cp));
        chk($sformatf("v%0d cond_minus", idx), int'(cond_minus), int'(v.cm));
        chk($sformatf("v%0d park", idx), int'(alu_funct), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepts, wbs, last, lat;
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        op_valid = 1'b0;
        op_kind  = 2'b00;
        op_funct = 4'b0000;
        op_src   = '0;

        //                kind   funct    src    acc_sat acc_wrap sat err cp cm
        vecs[0]  = '{2'b00, 4'b0000,   500,   500,   500, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{2'b01, 4'b1000,   600,   999,  -948, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{2'b00, 4'b0000,   -40,   -40,   -40, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{2'b01, 4'b1010,    40,  -999,   448, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{2'b00, 4'b0000,     5,     5,     5, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{2'b10, 4'b1101,     3,     5,     5, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{2'b10, 4'b1100,     3,     5,     5, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{2'b10, 4'b1110,     7,     5,     5, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{2'b11, 4'b0000,     0,     5,     5, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{2'b10, 4'b1101,     3,     5,     5, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{2'b10, 4'b1111,     3,     5,     5, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{2'b01, 4'b0111,     9,     5,     5, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{2'b01, 4'b1001,    10,    -5,    -5, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{2'b01, 4'b1011,     0,     4,     4, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[14] = '{2'b00, 4'b0000, -1024,  -999, -1024, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[15] = '{2'b00, 4'b0000,  1023,   999,  1023, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[16] = '{2'b01, 4'b1001, -1000,   999,   -25, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[17] = '{2'b00, 4'b0000,   990,   990,   990, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[18] = '{2'b01, 4'b1000,    20,   999,  1010, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[19] = '{2'b00, 4'b0000,   999,   999,   999, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[20] = '{2'b00, 4'b0000,  -999,  -999,  -999, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[21] = '{2'b01, 4'b1000,  -100,  -999,   949, 1'b1, 1'b0, 1'b1, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst acc", int'(acc), 0);
        chk("rst cond", int'({cond_plus, cond_minus}), 0);
        chk("rst alu_in", int'({alu_in0, alu_in1}), 0);
        chk("rst alu_funct", int'(alu_funct), 0);
        chk("rst pulses", int'({wb_valid, sat, op_err}), 0);
        chk("rst op_ready", int'(op_ready), 1);

        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i], i);
        end

        // Back-to-back: op_valid held high accepts exactly every third cycle.
        @(negedge clk);
        op_valid = 1'b1;
        op_kind  = 2'b00;
        op_funct = 4'b0000;
        op_src   = W'(7);
        accepts  = 0;
        wbs      = 0;
        last     = -1;
        for (int c = 0; c < 9; c++) begin
            if (op_ready) begin
                accepts++;
                if (last >= 0) chk("b2b gap", c - last, 3);
                last = c;
            end
            @(posedge clk);
            @(negedge clk);
            if (wb_valid) wbs++;
        end
        op_valid = 1'b0;
        chk("b2b accepts", accepts, 3);
        chk("b2b retires", wbs, 3);
        chk("b2b acc", $signed(acc), 7);

        // Reset during SETTLE aborts the op and clears everything at once.
        @(negedge clk);
        op_valid = 1'b1;
        op_kind  = 2'b01;
        op_funct = 4'b1000;
        op_src   = W'(10);
        @(posedge clk);
        #1 op_valid = 1'b0;
        @(negedge clk);
        chk("abort pre funct", int'(alu_funct), 8);
        chk("abort pre cond", int'(cond_plus), 1);
        reset = 1'b1;
        #1;
        chk("abort acc", int'(acc), 0);
        chk("abort alu_funct", int'(alu_funct), 0);
        chk("abort alu_in", int'({alu_in0, alu_in1}), 0);
        chk("abort cond", int'({cond_plus, cond_minus}), 0);
        chk("abort wb_valid", int'(wb_valid), 0);
        @(posedge clk);
        #1 chk("abort wb_hold", int'(wb_valid), 0);
        @(negedge clk);
        reset    = 1'b0;
        op_valid = 1'b1;
        op_kind  = 2'b00;
        op_funct = 4'b0000;
        op_src   = W'(12);
        #1 chk("post ready", int'(op_ready), 1);
        @(posedge clk);
        #1 op_valid = 1'b0;
        @(negedge clk);
        lat = 0;
        while (!wb_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        chk("post latency", lat, 2);
        chk("post acc", $signed(acc), 12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
